ws2812_tx: RTL

Serial line transmitter for the NeoPixel (WS2812-class) LED chain: accepts 24-bit GRB pixel words over a valid/ready handshake and drives the single-wire NRZ waveform, with each bit encoded as a timed high pulse followed by low time. It sits between the frame/pixel fetch logic and the LED data pin. When no next pixel is available at the end of a word, it inserts the low latch (reset) gap. It also pulses a done strobe, which the upstream frame sequencer consumes through the existing edge-to-enable logic.

---
 rtl/ws2812_pkg.sv | 28 ++
 rtl/ws2812_bit_gen.sv | 58 +++++
 rtl/ws2812_tx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// ============================================================================
// Module   : ws2812_pkg
// Brief    : Shared types and default 50 MHz timing for the WS2812 transmitter
// Revision : 1.0
// ============================================================================
`default_nettype none

package ws2812_pkg;

    localparam int DEF_BIT_CNT = 63;
    localparam int DEF_T0H_CNT = 20;
    localparam int DEF_T1H_CNT = 40;
    localparam int DEF_RST_CNT = 14000;

    localparam int PIXEL_W = 24;

    // Green, red, blue bytes from MSB down; bit 23 leaves the pin first.
    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ws2812_bit_gen.sv
// ============================================================================
// Module   : ws2812_bit_gen
// Brief    : Per-bit phase counter and high-time compare for the NRZ line
// Revision : 1.0
// ============================================================================
`default_nettype none

module ws2812_bit_gen #(
    parameter int BIT_CNT = 63,
    parameter int T0H_CNT = 20,
    parameter int T1H_CNT = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic send_next,
    input  logic bit_next,
    output logic level,
    output logic bit_end
);

    localparam int PW = $clog2(BIT_CNT);
    localparam logic [PW-1:0] C_LAST = PW'(BIT_CNT - 1);
    localparam logic [PW-1:0] C_T0H  = PW'(T0H_CNT);
    localparam logic [PW-1:0] C_T1H  = PW'(T1H_CNT);
    localparam logic [PW-1:0] C_ONE  = PW'(1);

    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_next;
    logic          r_level;
    logic          w_level_next;

    assign bit_end = run && (r_phase == C_LAST);
    assign level   = r_level;

    // The line level is computed from the next phase so the pin flop
    // lines up with the phase it describes, with no extra cycle of latency.
    always_comb begin
        w_phase_next = '0;
        if (run && !bit_end) begin
            w_phase_next = r_phase + C_ONE;
        end
        w_level_next = send_next && (w_phase_next < (bit_next ? C_T1H : C_T0H));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
            r_level <= 1'b0;
        end else begin
            r_phase <= w_phase_next;
            r_level <= w_level_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ws2812_tx.sv
// ============================================================================
// Module   : ws2812_tx
// Brief    : WS2812 single-wire transmitter: GRB word handshake, NRZ bit
//            stream and latch gap with done strobe
// Revision : 1.0
// ============================================================================
`default_nettype none

module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int BIT_CNT = DEF_BIT_CNT,
    parameter int T0H_CNT = DEF_T0H_CNT,
    parameter int T1H_CNT = DEF_T1H_CNT,
    parameter int RST_CNT = DEF_RST_CNT
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [PIXEL_W-1:0] data_in,
    input  logic               data_valid_in,
    output logic               data_ready_out,
    output logic               bit_out,
    output logic               busy_out,
    output logic               done_out
);

    localparam int LW = $clog2(RST_CNT + 1);
    localparam logic [LW-1:0] C_LATCH_LAST = LW'(RST_CNT - 1);
    localparam logic [LW-1:0] C_LATCH_ONE  = LW'(1);
    localparam logic [4:0]    C_IDX_TOP    = 5'd23;

    generate
        if (!(T0H_CNT > 0 && T0H_CNT < T1H_CNT && T1H_CNT < BIT_CNT && RST_CNT >= 1)) begin : g_param_check
            $error("ws2812_tx: illegal timing parameters");
        end
    endgenerate

    state_t        r_state;
    state_t        w_state_next;
    pixel_t        r_shift;
    pixel_t        w_shift_next;
    logic [4:0]    r_idx;
    logic [4:0]    w_idx_next;
    logic [LW-1:0] r_latch;
    logic [LW-1:0] w_latch_next;
    logic          r_busy;
    logic          w_bit_next;
    logic          w_ready;
    logic          w_done;
    logic          w_bit_end;
    logic          w_run;
    logic          w_send_next;

    assign w_run       = (r_state == SEND);
    assign w_send_next = (w_state_next == SEND);

    ws2812_bit_gen #(
        .BIT_CNT (BIT_CNT),
        .T0H_CNT (T0H_CNT),
        .T1H_CNT (T1H_CNT)
    ) u_bit_gen (
        .clk       (clk_in),
        .rst       (rst_in),
        .run       (w_run),
        .send_next (w_send_next),
        .bit_next  (w_bit_next),
        .level     (bit_out),
        .bit_end   (w_bit_end)
    );

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_idx_next   = r_idx;
        w_latch_next = r_latch;
        w_bit_next   = r_shift[PIXEL_W-1];
        w_ready      = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (data_valid_in) begin
                    w_state_next = SEND;
                    w_shift_next = data_in;
                    w_idx_next   = C_IDX_TOP;
                    w_bit_next   = data_in[PIXEL_W-1];
                end
            end
            SEND: begin
                if (w_bit_end) begin
                    if (r_idx == 5'd0) begin
                        // Only window in SEND where a follow-on word can chain in gap-free.
                        w_ready = 1'b1;
                        if (data_valid_in) begin
                            w_shift_next = data_in;
                            w_idx_next   = C_IDX_TOP;
                            w_bit_next   = data_in[PIXEL_W-1];
                        end else begin
                            w_state_next = LATCH;
                            w_latch_next = '0;
                        end
                    end else begin
                        w_idx_next   = r_idx - 5'd1;
                        w_shift_next = {r_shift[PIXEL_W-2:0], 1'b0};
                        w_bit_next   = r_shift[PIXEL_W-2];
                    end
                end
            end
            LATCH: begin
                if (r_latch == C_LATCH_LAST) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                    w_latch_next = '0;
                end else begin
                    w_latch_next = r_latch + C_LATCH_ONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_latch <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_idx   <= w_idx_next;
            r_latch <= w_latch_next;
            r_busy  <= (w_state_next != IDLE);
        end
    end

    assign data_ready_out = w_ready && !rst_in;
    assign done_out       = w_done;
    assign busy_out       = r_busy;

endmodule

`default_nettype wire
